// File: rtl/moore_pkg.sv
// Shared widths and token type for the Moore machine and its b_out consumers.
package moore_pkg;

    localparam int SYM_W   = 2;
    localparam int STATE_W = 3;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } rle_tok_t;

endpackage

// File: rtl/rle_token_fifo.sv
// First-word fall-through token FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module rle_token_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 6,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_level == '0);
    assign full   = (r_level == LW'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign level  = r_level;
    assign dout   = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/moore_out_rle.sv
// Run-length encoder for the Moore machine's b_out stream, feeding a small
// token FIFO so a stalled consumer never stalls the FSM.
module moore_out_rle #(
    parameter int  SYM_W      = moore_pkg::SYM_W,
    parameter int  CNT_W      = moore_pkg::CNT_W,
    parameter int  FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_en,
    input  logic             flush,
    output logic [SYM_W-1:0] tok_sym,
    output logic [CNT_W-1:0] tok_cnt,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int            TW      = SYM_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_run_active;
    logic [SYM_W-1:0] r_run_sym;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_overflow;

    logic             w_nxt_active;
    logic [SYM_W-1:0] w_nxt_sym;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_emit;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [TW-1:0]    w_head;

    always_comb begin
        w_nxt_active = r_run_active;
        w_nxt_sym    = r_run_sym;
        w_nxt_cnt    = r_run_cnt;
        w_emit       = 1'b0;
        if (flush) begin
            w_emit = r_run_active;
            if (sym_en) begin
                w_nxt_active = 1'b1;
                w_nxt_sym    = sym_in;
                w_nxt_cnt    = CNT_W'(1);
            end else begin
                w_nxt_active = 1'b0;
            end
        end else if (sym_en && !r_run_active) begin
            w_nxt_active = 1'b1;
            w_nxt_sym    = sym_in;
            w_nxt_cnt    = CNT_W'(1);
        end else if (sym_en && sym_in == r_run_sym && r_run_cnt != CNT_MAX) begin
            w_nxt_cnt = r_run_cnt + 1'b1;
        end else if (sym_en) begin
            // symbol change or saturated run: close it and restart at 1
            w_emit    = 1'b1;
            w_nxt_sym = sym_in;
            w_nxt_cnt = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_active <= 1'b0;
            r_run_sym    <= '0;
            r_run_cnt    <= '0;
        end else begin
            r_run_active <= w_nxt_active;
            r_run_sym    <= w_nxt_sym;
            r_run_cnt    <= w_nxt_cnt;
        end
    end

    assign w_pop = tok_valid & tok_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_emit && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    rle_token_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_emit),
        .din   ({r_run_sym, r_run_cnt}),
        .pop   (tok_ready),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign tok_valid = ~w_empty;
    assign tok_sym   = w_head[TW-1:CNT_W];
    assign tok_cnt   = w_head[CNT_W-1:0];
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_moore_out_rle.sv
// Directed scenarios for the b_out run-length encoder and its token FIFO.
module tb_moore_out_rle;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sym_in = '0;
    logic       sym_en = 1'b0;
    logic       flush = 1'b0;
    logic       tok_ready = 1'b0;
    logic [1:0] tok_sym;
    logic [3:0] tok_cnt;
    logic       tok_valid;
    logic       overflow;
    logic [2:0] fifo_level;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    moore_out_rle dut (
        .clk        (clk),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_en     (sym_en),
        .flush      (flush),
        .tok_sym    (tok_sym),
        .tok_cnt    (tok_cnt),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    // drive one cycle of inputs at a negedge, return at the next negedge
    task automatic cyc(input logic en, input logic [1:0] s,
                       input logic fl, input logic rdy);
        sym_en = en; sym_in = s; flush = fl; tok_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        sym_en = 1'b0; flush = 1'b0; tok_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level, overflow} !== 11'd0) begin
            fails++;
            $display("FAIL reset_state got v=%b s=%0d c=%0d l=%0d o=%b want all 0",
                     tok_valid, tok_sym, tok_cnt, fifo_level, overflow);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1, 2, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 2, 0, 1);
        tests++;
        if (tok_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_no_early_tok got v=%b want 0", tok_valid);
        end
        cyc(1, 1, 0, 0);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt} !== {1'b1, 2'd2, 4'd3}) begin
            fails++;
            $display("FAIL basic_tok0 got v=%b (%0d,%0d) want (2,3)",
                     tok_valid, tok_sym, tok_cnt);
        end
        cyc(0, 0, 1, 1);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level} !== {1'b1, 2'd1, 4'd1, 3'd1}) begin
            fails++;
            $display("FAIL basic_tok1 got v=%b (%0d,%0d) l=%0d want (1,1) l=1",
                     tok_valid, tok_sym, tok_cnt, fifo_level);
        end
        cyc(0, 0, 0, 1);
        tests++;
        if ({tok_valid, fifo_level, overflow} !== 5'd0) begin
            fails++;
            $display("FAIL basic_drained got v=%b l=%0d o=%b want 0 0 0",
                     tok_valid, fifo_level, overflow);
        end
        cyc(0, 0, 0, 1);
        tests++;
        if ({tok_valid, fifo_level} !== 4'd0) begin
            fails++;
            $display("FAIL basic_no_underflow got v=%b l=%0d want 0 0",
                     tok_valid, fifo_level);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1, 3, 0, 0);
        tests++;
        if (tok_valid !== 1'b0) begin
            fails++;
            $display("FAIL sat_at_max got v=%b want 0", tok_valid);
        end
        cyc(1, 3, 0, 0);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level} !== {1'b1, 2'd3, 4'd15, 3'd1}) begin
            fails++;
            $display("FAIL sat_split got v=%b (%0d,%0d) l=%0d want (3,15) l=1",
                     tok_valid, tok_sym, tok_cnt, fifo_level);
        end
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0);
        tests++;
        if (fifo_level !== 3'd2) begin
            fails++;
            $display("FAIL sat_level got %0d want 2", fifo_level);
        end
        cyc(0, 0, 0, 1);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt} !== {1'b1, 2'd3, 4'd2}) begin
            fails++;
            $display("FAIL sat_rem got v=%b (%0d,%0d) want (3,2)",
                     tok_valid, tok_sym, tok_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_s;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 2'(i % 2), 0, 0);
        tests++;
        if ({fifo_level, overflow} !== {3'd4, 1'b0}) begin
            fails++;
            $display("FAIL ovf_full got l=%0d o=%b want l=4 o=0",
                     fifo_level, overflow);
        end
        cyc(1, 1, 0, 0);
        tests++;
        if ({fifo_level, overflow} !== {3'd4, 1'b1}) begin
            fails++;
            $display("FAIL ovf_drop got l=%0d o=%b want l=4 o=1",
                     fifo_level, overflow);
        end
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_s = 2'(i % 2);
            tests++;
            if ({tok_valid, tok_sym, tok_cnt} !== {1'b1, exp_s, 4'd1}) begin
                fails++;
                $display("FAIL ovf_order[%0d] got v=%b (%0d,%0d) want (%0d,1)",
                         i, tok_valid, tok_sym, tok_cnt, exp_s);
            end
            cyc(0, 0, 0, 1);
        end
        tests++;
        if ({tok_valid, overflow} !== 2'b01) begin
            fails++;
            $display("FAIL ovf_sticky got v=%b o=%b want v=0 o=1",
                     tok_valid, overflow);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 2'(i % 2), 0, 0);
        cyc(1, 1, 0, 1);
        tests++;
        if ({fifo_level, overflow, tok_sym, tok_cnt} !== {3'd4, 1'b0, 2'd1, 4'd1}) begin
            fails++;
            $display("FAIL fullpop got l=%0d o=%b head=(%0d,%0d) want l=4 o=0 (1,1)",
                     fifo_level, overflow, tok_sym, tok_cnt);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level} !== {1'b1, 2'd0, 4'd1, 3'd1}) begin
            fails++;
            $display("FAIL fullpop_tail got v=%b (%0d,%0d) l=%0d want (0,1) l=1",
                     tok_valid, tok_sym, tok_cnt, fifo_level);
        end
    endtask

    task automatic test_flush_sym();
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level} !== {1'b1, 2'd1, 4'd2, 3'd1}) begin
            fails++;
            $display("FAIL flushsym_tok got v=%b (%0d,%0d) l=%0d want (1,2) l=1",
                     tok_valid, tok_sym, tok_cnt, fifo_level);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level} !== {1'b1, 2'd0, 4'd1, 3'd1}) begin
            fails++;
            $display("FAIL flushsym_new got v=%b (%0d,%0d) l=%0d want (0,1) l=1",
                     tok_valid, tok_sym, tok_cnt, fifo_level);
        end
        cyc(0, 0, 1, 1);
        tests++;
        if (tok_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle got v=%b want 0", tok_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0);
        tests++;
        if (fifo_level !== 3'd2) begin
            fails++;
            $display("FAIL rstmid_pre got l=%0d want 2", fifo_level);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({tok_valid, fifo_level, tok_sym, tok_cnt} !== 10'd0) begin
            fails++;
            $display("FAIL rstmid_async got v=%b l=%0d (%0d,%0d) want all 0",
                     tok_valid, fifo_level, tok_sym, tok_cnt);
        end
        #99 reset = 1'b0;
        @(negedge clk);
        cyc(1, 3, 0, 0);
        tests++;
        if (tok_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_no_partial got v=%b want 0", tok_valid);
        end
        cyc(1, 1, 0, 0);
        tests++;
        if ({tok_valid, tok_sym, tok_cnt, fifo_level} !== {1'b1, 2'd3, 4'd1, 3'd1}) begin
            fails++;
            $display("FAIL rstmid_restart got v=%b (%0d,%0d) l=%0d want (3,1) l=1",
                     tok_valid, tok_sym, tok_cnt, fifo_level);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_full_pop();
        test_flush_sym();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
